// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Arbitration is
//   round-robin and only one operation is in flight at a time. A granted
//   operation's operands are latched onto the alu_* outputs and held for
//   SETTLE cycles. The ALU outputs are then captured and returned with the
//   requester id on a valid/ready response port.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]       per-requester request handshake
//   req_src1/req_src2   [2*W-1:0]   {r1,r0} operands
//   req_ctrl [7:0], req_bonus [5:0] {r1,r0} ALU control / bonus codes
//   alu_src1/src2/ctrl/bonus        registered drive to the shared ALU
//   alu_result/cout/overflow        combinational ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/result/zero/cout/overflow captured response fields
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_src1,
    input  logic [2*WIDTH-1:0]   req_src2,
    input  logic [7:0]           req_ctrl,
    input  logic [5:0]           req_bonus,
    output logic [WIDTH-1:0]     alu_src1,
    output logic [WIDTH-1:0]     alu_src2,
    output logic [3:0]           alu_ctrl,
    output logic [2:0]           alu_bonus,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_cout,
    output logic                 rsp_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ptr;
    logic               r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_gid;
    logic               w_last;

    logic [WIDTH-1:0]   r_alu_src1;
    logic [WIDTH-1:0]   r_alu_src2;
    logic [3:0]         r_alu_ctrl;
    logic [2:0]         r_alu_bonus;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_cout;
    logic               r_rsp_overflow;

    // Round-robin grant; ready is suppressed while reset is held so nothing is
    // offered to a requester that the FSM cannot yet accept.
    always_comb begin
        w_grant = 2'b00;
        if (rst_n && (r_state == ST_IDLE)) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end else begin
            w_grant = 2'b00;
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);
    assign w_gid     = w_grant[1];
    assign w_last    = (r_cnt == CNT_LAST);

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_EXEC;
                else          w_state_nxt = ST_IDLE;
            end
            ST_EXEC: begin
                if (w_last) w_state_nxt = ST_RESP;
                else        w_state_nxt = ST_EXEC;
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Arbitration pointer, in-flight id and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
            r_id  <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_gid;
                        r_ptr <= ~w_gid;
                        r_cnt <= '0;
                    end
                end
                ST_EXEC: begin
                    if (w_last) r_cnt <= '0;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ALU drive registers: loaded only on a request handshake, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_src1  <= '0;
            r_alu_src2  <= '0;
            r_alu_ctrl  <= 4'd0;
            r_alu_bonus <= 3'd0;
        end else if (w_accept) begin
            r_alu_src1  <= w_gid ? req_src1[2*WIDTH-1:WIDTH] : req_src1[WIDTH-1:0];
            r_alu_src2  <= w_gid ? req_src2[2*WIDTH-1:WIDTH] : req_src2[WIDTH-1:0];
            r_alu_ctrl  <= w_gid ? req_ctrl[7:4]  : req_ctrl[3:0];
            r_alu_bonus <= w_gid ? req_bonus[5:3] : req_bonus[2:0];
        end
    end

    // Response capture on the last settle cycle; fields hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_zero     <= 1'b0;
            r_rsp_cout     <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else if ((r_state == ST_EXEC) && w_last) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_id       <= r_id;
            r_rsp_result   <= alu_result;
            r_rsp_zero     <= ~|alu_result;
            r_rsp_cout     <= alu_cout;
            r_rsp_overflow <= alu_overflow;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    assign alu_src1     = r_alu_src1;
    assign alu_src2     = r_alu_src2;
    assign alu_ctrl     = r_alu_ctrl;
    assign alu_bonus    = r_alu_bonus;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_overflow = r_rsp_overflow;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_src1;
    logic [63:0]  req_src2;
    logic [7:0]   req_ctrl;
    logic [5:0]   req_bonus;
    logic [31:0]  alu_src1;
    logic [31:0]  alu_src2;
    logic [3:0]   alu_ctrl;
    logic [2:0]   alu_bonus;
    logic [31:0]  alu_result;
    logic         alu_cout;
    logic         alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_zero;
    logic         rsp_cout;
    logic         rsp_overflow;

    int checks;
    int failures;

    alu_arbiter #(.WIDTH(32), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .req_ctrl(req_ctrl), .req_bonus(req_bonus),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal ALU stand-in: AND, OR, ADD.
    logic [32:0] sum;
    always_comb begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = 32'd0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b0010: begin
                alu_result   = sum[31:0];
                alu_cout     = sum[32];
                alu_overflow = (alu_src1[31] == alu_src2[31]) && (sum[31] != alu_src1[31]);
            end
            default: alu_result = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_src1 = {32'd9, 32'd8}; req_src2 = {32'd7, 32'd6};
        req_ctrl = 8'h22; req_bonus = 6'd0;
        tick(); tick();
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (alu_ctrl !== 4'd0) begin failures++; $display("FAIL reset_alu_ctrl got=%h exp=0", alu_ctrl); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_add();
        req_src1 = {32'd0, 32'd5}; req_src2 = {32'd0, 32'd7}; req_ctrl = 8'h02;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b exp=0", rsp_valid); end
        checks++; if (alu_src1 !== 32'd5 || alu_src2 !== 32'd7) begin failures++; $display("FAIL add_alu_src got=%0d,%0d exp=5,7", alu_src1, alu_src2); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_latency got=%b exp=1", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin failures++; $display("FAIL add_result got=%0d exp=12", rsp_result); end
        checks++; if (rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin failures++; $display("FAIL add_id_zero got=%b%b exp=00", rsp_id, rsp_zero); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_drop got=%b exp=0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int n;
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        req_src1 = {32'd10, 32'd1}; req_src2 = {32'd20, 32'd2}; req_ctrl = 8'h22;
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_timeout op=%0d got=%b exp=1", k, rsp_valid); end
            checks++; if (rsp_id !== k[0]) begin failures++; $display("FAIL rr_id op=%0d got=%b exp=%b", k, rsp_id, k[0]); end
            checks++; if (rsp_result !== (k[0] ? 32'd30 : 32'd3)) begin failures++; $display("FAIL rr_result op=%0d got=%0d exp=%0d", k, rsp_result, k[0] ? 30 : 3); end
            tick();
        end
        req_valid = 2'b00; rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_stall();
        req_src1 = {32'h0000_000F, 32'h0000_00F0}; req_src2 = {32'h0000_00F0, 32'h0000_00FF};
        req_ctrl = 8'h10; req_bonus = 6'b101_000;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h0000_00F0)
                begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h exp=1/0/000000f0", c, rsp_valid, rsp_id, rsp_result); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=00", c, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin failures++; $display("FAIL stall_release got=%b/%b exp=0/10", rsp_valid, req_ready); end
        tick();
        req_valid = 2'b00;
        #1;
        checks++; if (alu_ctrl !== 4'b0001 || alu_bonus !== 3'b101) begin failures++; $display("FAIL stall_r1_drive got=%h/%b exp=1/101", alu_ctrl, alu_bonus); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h0000_00FF)
            begin failures++; $display("FAIL stall_r1_rsp got=%b/%b/%h exp=1/1/000000ff", rsp_valid, rsp_id, rsp_result); end
        tick();
        rsp_ready = 1'b0; req_bonus = 6'd0;
    endtask

    task automatic test_and_zero();
        req_src1 = {32'd0, 32'h0000_00F0}; req_src2 = {32'd0, 32'h0000_000F}; req_ctrl = 8'h00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
            begin failures++; $display("FAIL and_zero got=%b/%h/%b exp=1/00000000/1", rsp_valid, rsp_result, rsp_zero); end
        checks++; if (alu_src1 !== 32'h0000_00F0) begin failures++; $display("FAIL and_alu_hold got=%h exp=000000f0", alu_src1); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_carry();
        logic [31:0] a [2];
        logic [31:0] er [2];
        logic [1:0]  ef [2];
        a[0] = 32'hFFFF_FFFF; er[0] = 32'h0000_0000; ef[0] = 2'b10;
        a[1] = 32'h7FFF_FFFF; er[1] = 32'h8000_0000; ef[1] = 2'b01;
        for (int v = 0; v < 2; v++) begin
            req_src1 = {a[v], 32'd0}; req_src2 = {32'd1, 32'd0}; req_ctrl = 8'h20;
            req_valid = 2'b10;
            tick();
            req_valid = 2'b00;
            tick();
            checks++; if (rsp_result !== er[v] || {rsp_cout, rsp_overflow} !== ef[v] || rsp_zero !== (v == 0))
                begin failures++; $display("FAIL carry v=%0d got=%h/%b%b/%b exp=%h/%b", v, rsp_result, rsp_cout, rsp_overflow, rsp_zero, er[v], ef[v]); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_exec();
        req_src1 = {32'd0, 32'd1}; req_src2 = {32'd0, 32'd1}; req_ctrl = 8'h02;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || alu_ctrl !== 4'd0) begin failures++; $display("FAIL rexec_during got=%b/%h exp=0/0", rsp_valid, alu_ctrl); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rexec_no_rsp got=%b exp=0", rsp_valid); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rexec_idle_ptr got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_src1 = 64'd0; req_src2 = 64'd0; req_ctrl = 8'd0; req_bonus = 6'd0;
        test_reset();
        test_add();
        test_round_robin();
        test_stall();
        test_and_zero();
        test_carry();
        test_reset_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
